// File: rtl/seven_seg_scan_reader_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_reader_pkg
// Shared definitions for the 7-segment scan reader and the display checkers.
// Segment vectors are ordered {a,b,c,d,e,f,g} (bit6 = a), active-low:
// a 0 bit means the segment is lit.
// Contents:
//   SEG_0..SEG_9, SEG_BLANK : reference segment patterns
//   CODE_BLANK, CODE_INVALID: special digit codes
//   state_t                 : frame assembly state
// ---------------------------------------------------------------------------
package seven_seg_scan_reader_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b1100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK   = 4'hE;
  localparam logic [3:0] CODE_INVALID = 4'hF;

  typedef enum logic {
    COLLECT = 1'b0,
    PUBLISH = 1'b1
  } state_t;

endpackage

// File: rtl/seven_seg_scan_reader_decode.sv
// ---------------------------------------------------------------------------
// seven_seg_pattern_decode
// Combinational 7-segment pattern to digit code translation.
// Ports:
//   seg     in  [6:0] active-low segment pattern {a..g}
//   code    out [3:0] 0..9, CODE_BLANK for an all-dark digit, else CODE_INVALID
//   invalid out       high when the pattern is neither a digit nor blank
// ---------------------------------------------------------------------------
module seven_seg_pattern_decode
  import seven_seg_scan_reader_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       invalid
);

  always_comb begin
    code    = CODE_INVALID;
    invalid = 1'b0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default: begin
        code    = CODE_INVALID;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_reader.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_reader
// Samples a time-multiplexed 4-digit 7-segment bus (shared active-low
// segments, active-low anodes), rebuilds the mm:ss BCD digits and publishes
// each complete frame with a one-cycle frame_valid strobe.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   seg_in [6:0]      segments {a..g}, active-low, asynchronous to clk
//   an_in  [3:0]      anodes, active-low; [0]=s unit .. [3]=m tens
//   second_unit, second_tens, minute_unit, minute_tens [3:0]
//                     last published digit codes
//   frame_valid       one-cycle pulse when the digit outputs update
//   digit_err [3:0]   per-digit undecodable-pattern flags of that frame
//   bus_err           pulse: a settled sample had several anodes active
//   frame_timeout     pulse: a partial frame was abandoned
//   err_count [15:0]  (only with SEVEN_SEG_READER_ERR_CNT_EN) saturating
//                     count of erroneous frames plus bus errors
// Optional build macro: SEVEN_SEG_READER_ERR_CNT_EN
// ---------------------------------------------------------------------------
module seven_seg_scan_reader
  import seven_seg_scan_reader_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic [3:0] an_in,
  output logic [3:0] second_unit,
  output logic [3:0] second_tens,
  output logic [3:0] minute_unit,
  output logic [3:0] minute_tens,
  output logic       frame_valid,
  output logic [3:0] digit_err,
  output logic       bus_err,
  output logic       frame_timeout
`ifdef SEVEN_SEG_READER_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int STAB_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(SETTLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_PRE  = STAB_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  // ---------------- input synchronizers ----------------
  // Reset to the idle bus (all dark, no anode) so nothing is captured
  // from the flops' reset contents.
  logic [6:0] seg_sync_reg [SYNC_STAGES];
  logic [3:0] an_sync_reg  [SYNC_STAGES];

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          seg_sync_reg[gi] <= '1;
          an_sync_reg[gi]  <= '1;
        end else begin
          seg_sync_reg[gi] <= seg_in;
          an_sync_reg[gi]  <= an_in;
        end
      end
    end else begin : g_rest
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          seg_sync_reg[gi] <= '1;
          an_sync_reg[gi]  <= '1;
        end else begin
          seg_sync_reg[gi] <= seg_sync_reg[gi-1];
          an_sync_reg[gi]  <= an_sync_reg[gi-1];
        end
      end
    end
  end

  logic [6:0]  seg_s;
  logic [3:0]  an_s;
  logic [3:0]  an_low;
  logic [10:0] sample;
  assign seg_s  = seg_sync_reg[SYNC_STAGES-1];
  assign an_s   = an_sync_reg[SYNC_STAGES-1];
  assign an_low = ~an_s;
  assign sample = {an_s, seg_s};

  // ---------------- stability detection ----------------
  logic [10:0]       prev_reg;
  logic [STAB_W-1:0] stab_reg, stab_next;
  logic              same, fire, one_hot, multi, capture, bus_hit;

  assign same = (sample == prev_reg);

  always_comb begin
    stab_next = STAB_W'(1);
    if (same) begin
      stab_next = (stab_reg == STAB_MAX) ? stab_reg : stab_reg + STAB_W'(1);
    end
  end

  // Fires on the single cycle the counter steps onto SETTLE_CYCLES; with a
  // settle of one, every change of sample is itself the capture point.
  assign fire    = same ? (stab_reg == STAB_PRE) : (SETTLE_CYCLES == 1);
  assign one_hot = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
  assign multi   = (an_low != 4'd0) && !one_hot;
  assign capture = fire && one_hot;
  assign bus_hit = fire && multi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg <= '1;
      stab_reg <= '0;
    end else begin
      prev_reg <= sample;
      stab_reg <= stab_next;
    end
  end

  // ---------------- decode and staging ----------------
  logic [3:0] dec_code;
  logic       dec_invalid;

  seven_seg_pattern_decode u_decode (
    .seg     (seg_s),
    .code    (dec_code),
    .invalid (dec_invalid)
  );

  logic [3:0] slot_reg     [NUM_DIGITS];
  logic       slot_err_reg [NUM_DIGITS];
  logic [3:0] stage_err;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_reg[gi]     <= 4'h0;
        slot_err_reg[gi] <= 1'b0;
      end else if (capture && an_low[gi]) begin
        slot_reg[gi]     <= dec_code;
        slot_err_reg[gi] <= dec_invalid;
      end
    end
    assign stage_err[gi] = slot_err_reg[gi];
  end

  // ---------------- frame FSM ----------------
  state_t          state_reg, state_next;
  logic            publish;
  logic [3:0]      seen_reg, seen_next;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic            timeout_hit;

  // A capture always restarts the timeout, so it can never coincide with it.
  assign timeout_hit = !capture && (to_cnt_reg == TO_LAST) && (seen_reg != 4'd0);

  always_comb begin
    seen_next = seen_reg;
    if (publish || timeout_hit) begin
      seen_next = 4'd0;
    end
    // Applied after the clear so a capture during PUBLISH opens the next frame.
    if (capture) begin
      seen_next = seen_next | an_low;
    end
  end

  always_comb begin
    to_cnt_next = to_cnt_reg;
    if (capture || timeout_hit) begin
      to_cnt_next = '0;
    end else if (to_cnt_reg != TO_LAST) begin
      to_cnt_next = to_cnt_reg + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (seen_next == 4'hF) state_next = PUBLISH;
      PUBLISH: state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    publish = (state_reg == PUBLISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_reg   <= 4'd0;
      to_cnt_reg <= '0;
    end else begin
      seen_reg   <= seen_next;
      to_cnt_reg <= to_cnt_next;
    end
  end

  // ---------------- published outputs ----------------
  logic [3:0] pub_reg [NUM_DIGITS];
  logic [3:0] digit_err_reg;
  logic       frame_valid_reg, bus_err_reg, frame_timeout_reg;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_pub
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pub_reg[gi] <= 4'h0;
      end else if (publish) begin
        pub_reg[gi] <= slot_reg[gi];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_err_reg     <= 4'd0;
      frame_valid_reg   <= 1'b0;
      bus_err_reg       <= 1'b0;
      frame_timeout_reg <= 1'b0;
    end else begin
      if (publish) begin
        digit_err_reg <= stage_err;
      end
      frame_valid_reg   <= publish;
      bus_err_reg       <= bus_hit;
      frame_timeout_reg <= timeout_hit;
    end
  end

  assign second_unit   = pub_reg[0];
  assign second_tens   = pub_reg[1];
  assign minute_unit   = pub_reg[2];
  assign minute_tens   = pub_reg[3];
  assign digit_err     = digit_err_reg;
  assign frame_valid   = frame_valid_reg;
  assign bus_err       = bus_err_reg;
  assign frame_timeout = frame_timeout_reg;

`ifdef SEVEN_SEG_READER_ERR_CNT_EN
  // Counts from the registered strobes, so an erroneous frame and a bus
  // error landing together add two.
  logic [15:0] err_count_reg;
  logic [16:0] err_sum;

  always_comb begin
    err_sum = {1'b0, err_count_reg}
            + 17'(frame_valid_reg && (digit_err_reg != 4'd0))
            + 17'(bus_err_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_reg <= 16'd0;
    end else begin
      err_count_reg <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
module tb_seven_seg_scan_reader;

  localparam int SYNC   = 2;
  localparam int SETTLE = 4;
  localparam int TMO    = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = 7'h7F;
  logic [3:0] an_in = 4'hF;
  logic [3:0] second_unit, second_tens, minute_unit, minute_tens;
  logic       frame_valid, bus_err, frame_timeout;
  logic [3:0] digit_err;
`ifdef SEVEN_SEG_READER_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  seven_seg_scan_reader #(
    .SYNC_STAGES    (SYNC),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg_in        (seg_in),
    .an_in         (an_in),
    .second_unit   (second_unit),
    .second_tens   (second_tens),
    .minute_unit   (minute_unit),
    .minute_tens   (minute_tens),
    .frame_valid   (frame_valid),
    .digit_err     (digit_err),
    .bus_err       (bus_err),
    .frame_timeout (frame_timeout)
`ifdef SEVEN_SEG_READER_ERR_CNT_EN
    ,
    .err_count     (err_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // ---------------- reference tables ----------------
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b1100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // ---------------- observation ----------------
  logic [19:0] obs_q[$];
  int obs_bus = 0;
  int obs_to  = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) obs_q.push_back({minute_tens, minute_unit, second_tens, second_unit, digit_err});
      if (bus_err) obs_bus++;
      if (frame_timeout) obs_to++;
    end
  end

  // ---------------- dwell-level reference model ----------------
  logic [3:0]  m_code [4];
  logic        m_err  [4];
  logic [3:0]  m_seen;
  logic [19:0] exp_q[$];
  int exp_bus = 0;
  int exp_to  = 0;
  logic [10:0] last_val;
  int run_len;

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_code[d] = 4'h0;
      m_err[d]  = 1'b0;
    end
    m_seen   = 4'h0;
    last_val = {4'hF, 7'h7F};
    run_len  = 0;
  endtask

  // A settled pattern is read as a digit when exactly one anode is low.
  task automatic model_capture(input logic [3:0] an, input logic [6:0] seg);
    int nlow;
    int idx;
    logic [3:0] code;
    logic bad;
    nlow = 0;
    idx  = 0;
    for (int d = 0; d < 4; d++) if (!an[d]) begin nlow++; idx = d; end
    if (nlow == 1) begin
      code = 4'hF;
      bad  = 1'b1;
      if (seg == 7'h7F) begin code = 4'hE; bad = 1'b0; end
      for (int v = 0; v < 10; v++) if (seg == seg_of(v)) begin code = 4'(v); bad = 1'b0; end
      m_code[idx] = code;
      m_err[idx]  = bad;
      m_seen[idx] = 1'b1;
      if (m_seen == 4'hF) begin
        exp_q.push_back({m_code[3], m_code[2], m_code[1], m_code[0],
                         m_err[3], m_err[2], m_err[1], m_err[0]});
        m_seen = 4'h0;
      end
    end else if (nlow >= 2) begin
      exp_bus++;
    end
  endtask

  // Hold a pin pattern for len cycles; fv_at is the first cycle of the
  // dwell on which frame_valid was seen (0 = none).
  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int len, output int fv_at);
    int prev_run;
    an_in  = an;
    seg_in = seg;
    fv_at  = 0;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      if (frame_valid && fv_at == 0) fv_at = i;
    end
    if ({an, seg} == last_val) begin
      prev_run = run_len;
      run_len  = run_len + len;
    end else begin
      prev_run = 0;
      run_len  = len;
      last_val = {an, seg};
    end
    if (prev_run < SETTLE && run_len >= SETTLE) model_capture(an, seg);
  endtask

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] a;
    a = 4'hF;
    a[d] = 1'b0;
    return a;
  endfunction

  task automatic flush_and_compare(input string tag);
    int dummy;
    dwell(4'hF, 7'h7F, 20, dummy);
    @(posedge clk);
    check_val({tag, "_nframes"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check_val({tag, "_frame"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
    check_val({tag, "_bus_err"}, obs_bus, exp_bus);
    check_val({tag, "_timeout"}, obs_to, exp_to);
    @(negedge clk);
  endtask

  function automatic logic [31:0] all_outputs();
    return {8'h0, second_unit, second_tens, minute_unit, minute_tens,
            digit_err, frame_valid, bus_err, frame_timeout, 1'b0};
  endfunction

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    an_in  = 4'hF;
    seg_in = 7'h7F;
    #1 check_val({tag, "_rst_async"}, all_outputs(), 32'h0);
    repeat (3) @(negedge clk);
    check_val({tag, "_rst_hold"}, all_outputs(), 32'h0);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fv;
    int acc;
    logic [3:0] a;
    logic [6:0] s;
    int len;
    int r;

    model_reset();
    repeat (2) @(negedge clk);
    do_reset("init");

    // 12:34 scan, and frame latency on the completing digit
    dwell(an_of(0), seg_of(4), 8, fv);
    dwell(an_of(1), seg_of(3), 8, fv);
    dwell(an_of(2), seg_of(2), 8, fv);
    dwell(an_of(3), seg_of(1), 8, fv);
    check_val("scan1234_latency", fv, SYNC + SETTLE + 1);
    flush_and_compare("scan1234");
    check_val("scan1234_outputs", {minute_tens, minute_unit, second_tens, second_unit, digit_err}, 20'h12340);

    // dwells one cycle short of settling never capture or time out
    for (int k = 0; k < 8; k++)
      for (int d = 0; d < 4; d++) dwell(an_of(d), seg_of((k + d) % 10), SETTLE - 1, fv);
    flush_and_compare("short_dwell");

    // two anodes low mid-scan: one bus error, scan still completes once
    dwell(an_of(0), seg_of(5), 8, fv);
    dwell(an_of(1), seg_of(6), 8, fv);
    dwell(an_of(2), seg_of(7), 8, fv);
    dwell(4'b1100, seg_of(8), 10, fv);
    dwell(an_of(3), seg_of(9), 8, fv);
    flush_and_compare("bus_err");
    check_val("bus_err_outputs", {minute_tens, minute_unit, second_tens, second_unit, digit_err}, 20'h97650);

    // undecodable second_unit, blank minute_tens
    dwell(an_of(0), 7'b1010101, 8, fv);
    dwell(an_of(1), seg_of(0), 8, fv);
    dwell(an_of(2), seg_of(8), 8, fv);
    dwell(an_of(3), 7'h7F, 8, fv);
    flush_and_compare("invalid_blank");
    check_val("invalid_blank_outputs", {minute_tens, minute_unit, second_tens, second_unit, digit_err}, 20'hE80F1);

    // partial frame abandoned after idle, then a fresh scan (tens first)
    dwell(an_of(0), seg_of(1), 8, fv);
    dwell(an_of(1), seg_of(2), 8, fv);
    dwell(an_of(2), seg_of(3), 8, fv);
    dwell(4'hF, 7'h7F, TMO + 16, fv);
    m_seen = 4'h0;
    exp_to++;
    dwell(an_of(3), seg_of(3), 8, fv);
    dwell(an_of(2), seg_of(4), 8, fv);
    dwell(an_of(1), seg_of(5), 8, fv);
    dwell(an_of(0), seg_of(6), 8, fv);
    flush_and_compare("timeout");
    check_val("timeout_outputs", {minute_tens, minute_unit, second_tens, second_unit, digit_err}, 20'h34560);

    // reset after two captures, then 59:59
    dwell(an_of(0), seg_of(2), 8, fv);
    dwell(an_of(1), seg_of(3), 8, fv);
    do_reset("midframe");
    dwell(an_of(0), seg_of(9), 8, fv);
    dwell(an_of(1), seg_of(5), 8, fv);
    dwell(an_of(2), seg_of(9), 8, fv);
    dwell(an_of(3), seg_of(5), 8, fv);
    flush_and_compare("after_reset");
    check_val("after_reset_outputs", {minute_tens, minute_unit, second_tens, second_unit, digit_err}, 20'h59590);

    // randomized bus traffic; long idle stretches are broken up so the
    // partial-frame timeout is never reached here
    acc = 0;
    for (int k = 0; k < 400; k++) begin
      do begin
        r = int'($urandom_range(0, 9));
        if (acc > 24 || r < 7) a = an_of(int'($urandom_range(0, 3)));
        else if (r == 7) a = 4'hF;
        else begin
          do a = 4'($urandom_range(0, 15)); while ($countones(~a) < 2);
        end
        r = int'($urandom_range(0, 9));
        if (acc > 24 || r < 7) s = seg_of(int'($urandom_range(0, 9)));
        else if (r == 7) s = 7'h7F;
        else s = 7'($urandom_range(0, 127));
        len = (acc > 24) ? int'($urandom_range(SETTLE, 10)) : int'($urandom_range(1, 10));
      end while ({a, s} == last_val);
      if ($countones(~a) == 1 && len >= SETTLE) acc = 0;
      else acc = acc + len;
      dwell(a, s, len, fv);
    end
    for (int d = 0; d < 4; d++)
      if (!m_seen[d]) dwell(an_of(d), seg_of(int'($urandom_range(0, 9))), 8, fv);
    flush_and_compare("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // hard stop in case stimulus stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
